alu_multicycle: RTL and testbench

//  Parametrised multi-cycle successor to the single-cycle datapath ALU: full RV32I integer op set,

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_shift_step.sv | 38 +++
 rtl/alu_multicycle.sv | 191 +++++++++++++++++++
 tb/tb_alu_multicycle.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU.
//   alu_op_e    : operation codes (RV32I integer set plus optional MUL)
//   alu_state_e : control FSM states
//   shamt_w()   : width of a shift amount for a given operand width
package alu_pkg;

  typedef enum logic [3:0] {
    AluAnd  = 4'd0,
    AluOr   = 4'd1,
    AluAdd  = 4'd2,
    AluXor  = 4'd3,
    AluSll  = 4'd4,
    AluSrl  = 4'd5,
    AluSub  = 4'd6,
    AluSra  = 4'd7,
    AluSlt  = 4'd8,
    AluSltu = 4'd9,
    AluMul  = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } alu_state_e;

  function automatic int unsigned shamt_w(input int unsigned xlen);
    return $clog2(xlen);
  endfunction

endpackage

// File: rtl/alu_shift_step.sv
// One iteration of the iterative shifter: shifts data by amount (0..SHIFT_STEP) bits.
// Built as a mux over the SHIFT_STEP+1 constant shifts so no full barrel shifter is inferred.
// Ports:
//   data      in   XLEN   value to shift
//   dir_right in   1      1 = right shift, 0 = left shift
//   arith     in   1      right shifts replicate the sign bit
//   amount    in   AmtW   bits to shift this step, never above SHIFT_STEP
//   result    out  XLEN   shifted value
module alu_shift_step
  import alu_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned SHIFT_STEP = 1,
  localparam int unsigned AmtW      = shamt_w(XLEN) + 1
) (
  input  logic [XLEN-1:0] data,
  input  logic            dir_right,
  input  logic            arith,
  input  logic [AmtW-1:0] amount,
  output logic [XLEN-1:0] result
);

  always_comb begin
    result = data;
    for (int unsigned k = 1; k <= SHIFT_STEP; k++) begin
      if (amount == AmtW'(k)) begin
        if (!dir_right) begin
          result = data << k;
        end else if (arith) begin
          result = $signed(data) >>> k;
        end else begin
          result = data >> k;
        end
      end
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle integer ALU between register-read and writeback.
// Single-step ops finish in one cycle; shifts iterate SHIFT_STEP bits per cycle; with
// ALU_MUL_EN defined, MUL runs a radix-2 shift-add over XLEN cycles. Without ALU_MUL_EN the
// MUL code decodes as unknown (out=0, zero=1) and no multiplier is built.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  input handshake (in_ready = FSM idle)
//   in_0, in_1           operands; shifts use in_1[SHAMT_W-1:0]
//   operation            op code (alu_op_e)
//   out_valid/out_ready  output handshake (out_valid = FSM done)
//   out, zero            registered result and (out == 0)
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_0,
  input  logic [XLEN-1:0] in_1,
  input  logic [3:0]      operation,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out,
  output logic            zero
);

  localparam int unsigned ShamtW = shamt_w(XLEN);
  // One extra bit so the counter can hold XLEN (MUL) and a step of SHIFT_STEP == XLEN.
  localparam int unsigned CntW = ShamtW + 1;
  localparam logic [CntW-1:0] StepC = CntW'(SHIFT_STEP);

  alu_state_e      state_q, state_d;
  alu_op_e         op_q, op_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] out_q, out_d;
  logic            zero_q, zero_d;

  alu_op_e         op_in;
  logic [ShamtW-1:0] shamt_in;
  logic            is_shift_in;
  logic [XLEN-1:0] single_res;
  logic [CntW-1:0] step_amt;
  logic [CntW-1:0] cnt_rem;
  logic [XLEN-1:0] shift_res;

  assign op_in       = alu_op_e'(operation);
  assign shamt_in    = in_1[ShamtW-1:0];
  assign is_shift_in = (op_in == AluSll) || (op_in == AluSrl) || (op_in == AluSra);

  // Last step takes only the remainder so the total never exceeds shamt.
  assign step_amt = (cnt_q > StepC) ? StepC : cnt_q;
  assign cnt_rem  = cnt_q - step_amt;

  alu_shift_step #(
    .XLEN      (XLEN),
    .SHIFT_STEP(SHIFT_STEP)
  ) u_shift_step (
    .data     (a_q),
    .dir_right(op_q != AluSll),
    .arith    (op_q == AluSra),
    .amount   (step_amt),
    .result   (shift_res)
  );

`ifdef ALU_MUL_EN
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] prod_q, prod_d;
  logic [XLEN-1:0] prod_sum;

  assign prod_sum = prod_q + (b_q[0] ? a_q : '0);
`endif

  // Results of ops that complete on the accept edge; shifts only land here with shamt 0.
  always_comb begin
    single_res = '0;
    case (op_in)
      AluAnd:  single_res = in_0 & in_1;
      AluOr:   single_res = in_0 | in_1;
      AluAdd:  single_res = in_0 + in_1;
      AluXor:  single_res = in_0 ^ in_1;
      AluSub:  single_res = in_0 - in_1;
      AluSlt:  single_res = {{(XLEN-1){1'b0}}, $signed(in_0) < $signed(in_1)};
      AluSltu: single_res = {{(XLEN-1){1'b0}}, in_0 < in_1};
      AluSll, AluSrl, AluSra: single_res = in_0;
      default: single_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    zero_d  = zero_q;
`ifdef ALU_MUL_EN
    b_d     = b_q;
    prod_d  = prod_q;
`endif
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          op_d = op_in;
          a_d  = in_0;
          if (is_shift_in && (shamt_in != '0)) begin
            cnt_d   = CntW'(shamt_in);
            state_d = StBusy;
`ifdef ALU_MUL_EN
          end else if (op_in == AluMul) begin
            b_d     = in_1;
            prod_d  = '0;
            cnt_d   = CntW'(XLEN);
            state_d = StBusy;
`endif
          end else begin
            out_d   = single_res;
            zero_d  = (single_res == '0);
            state_d = StDone;
          end
        end
      end
      StBusy: begin
`ifdef ALU_MUL_EN
        if (op_q == AluMul) begin
          prod_d = prod_sum;
          a_d    = a_q << 1;
          b_d    = b_q >> 1;
          cnt_d  = cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            out_d   = prod_sum;
            zero_d  = (prod_sum == '0);
            state_d = StDone;
          end
        end else
`endif
        begin
          a_d   = shift_res;
          cnt_d = cnt_rem;
          if (cnt_rem == '0) begin
            out_d   = shift_res;
            zero_d  = (shift_res == '0);
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      op_q    <= AluAnd;
      a_q     <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      zero_q  <= 1'b0;
`ifdef ALU_MUL_EN
      b_q     <= '0;
      prod_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      zero_q  <= zero_d;
`ifdef ALU_MUL_EN
      b_q     <= b_d;
      prod_q  <= prod_d;
`endif
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign out       = out_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: two instances (SHIFT_STEP=1 and 8) driven in lockstep.
module tb_alu_multicycle;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_0;
  logic [31:0] in_1;
  logic [3:0]  operation;
  logic        out_ready;

  logic        ir_a, ov_a, z_a;
  logic [31:0] out_a;
  logic        ir_b, ov_b, z_b;
  logic [31:0] out_b;

  int checks;
  int failures;

  alu_multicycle #(.XLEN(32), .SHIFT_STEP(1)) dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (ir_a),
    .in_0     (in_0),
    .in_1     (in_1),
    .operation(operation),
    .out_valid(ov_a),
    .out_ready(out_ready),
    .out      (out_a),
    .zero     (z_a)
  );

  alu_multicycle #(.XLEN(32), .SHIFT_STEP(8)) dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (ir_b),
    .in_0     (in_0),
    .in_1     (in_1),
    .operation(operation),
    .out_valid(ov_b),
    .out_ready(out_ready),
    .out      (out_b),
    .zero     (z_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: result and accept-to-valid latency from the arithmetic rules.
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input int step, output logic [31:0] r, output int lat);
    int sh;
    sh  = int'(b[4:0]);
    lat = 1;
    case (op)
      4'd0: r = a & b;
      4'd1: r = a | b;
      4'd2: r = a + b;
      4'd3: r = a ^ b;
      4'd4: begin r = a << sh; lat = 1 + (sh + step - 1) / step; end
      4'd5: begin r = a >> sh; lat = 1 + (sh + step - 1) / step; end
      4'd6: r = a - b;
      4'd7: begin r = $signed(a) >>> sh; lat = 1 + (sh + step - 1) / step; end
      4'd8: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9: r = (a < b) ? 32'd1 : 32'd0;
`ifdef ALU_MUL_EN
      4'd10: begin r = a * b; lat = 33; end
`endif
      default: r = 32'd0;
    endcase
  endfunction

  // Issue one op to both instances and record result/zero/latency of each.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] ra, output logic za, output int la,
                       output logic [31:0] rb, output logic zb, output int lb);
    int waited;
    ra = '0; za = 1'bx; la = 0;
    rb = '0; zb = 1'bx; lb = 0;
    @(negedge clk);
    chk("idle_before_accept", {30'd0, ir_a, ir_b}, 32'd3);
    operation = op;
    in_0      = a;
    in_1      = b;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      if (la == 0 && ov_a) begin la = c; ra = out_a; za = z_a; end
      if (lb == 0 && ov_b) begin lb = c; rb = out_b; zb = z_b; end
      if (la != 0 && lb != 0) break;
      @(posedge clk);
      #1;
    end
    waited = 0;
    while (!(ir_a && ir_b) && waited < 5) begin
      @(posedge clk);
      #1;
      waited++;
    end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        ez;
    int          lat1;
    int          lat8;
  } vec_t;

  vec_t vecs[17];

  initial begin
    logic [31:0] ra, rb, er;
    logic        za, zb;
    int          la, lb, el1, el8;

    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_0 = '0;
    in_1 = '0;
    operation = '0;
    out_ready = 1'b1;

    vecs[0]  = '{4'd2,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1, 1};
    vecs[1]  = '{4'd7,  32'h80000000, 32'd31,       32'hFFFFFFFF, 1'b0, 32, 5};
    vecs[2]  = '{4'd8,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1, 1};
    vecs[3]  = '{4'd9,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1, 1};
    vecs[4]  = '{4'd15, 32'h12345678, 32'h00000009, 32'h00000000, 1'b1, 1, 1};
    vecs[5]  = '{4'd4,  32'h00000001, 32'd20,       32'h00100000, 1'b0, 21, 4};
    vecs[6]  = '{4'd5,  32'h80000000, 32'd8,        32'h00800000, 1'b0, 9, 2};
    vecs[7]  = '{4'd4,  32'h00001234, 32'd32,       32'h00001234, 1'b0, 1, 1};
    vecs[8]  = '{4'd5,  32'hF0F0F0F0, 32'd36,       32'h0F0F0F0F, 1'b0, 5, 2};
    vecs[9]  = '{4'd3,  32'hAAAA5555, 32'hAAAA5555, 32'h00000000, 1'b1, 1, 1};
    vecs[10] = '{4'd0,  32'hF0F0FFFF, 32'h0FF0F00F, 32'h00F0F00F, 1'b0, 1, 1};
    vecs[11] = '{4'd1,  32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 1, 1};
    vecs[12] = '{4'd6,  32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1, 1};
    vecs[13] = '{4'd7,  32'h7FFFFFF0, 32'd4,        32'h07FFFFFF, 1'b0, 5, 2};
    vecs[14] = '{4'd4,  32'h80000001, 32'd8,        32'h00000100, 1'b0, 9, 2};
`ifdef ALU_MUL_EN
    vecs[15] = '{4'd10, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1, 33, 33};
    vecs[16] = '{4'd10, 32'h00000003, 32'h00000005, 32'h0000000F, 1'b0, 33, 33};
`else
    vecs[15] = '{4'd10, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1, 1, 1};
    vecs[16] = '{4'd10, 32'h00000003, 32'h00000005, 32'h00000000, 1'b1, 1, 1};
`endif

    // Reset state
    #12;
    chk("rst_out_valid", {31'd0, ov_a}, 32'd0);
    chk("rst_in_ready", {31'd0, ir_a}, 32'd1);
    chk("rst_out", out_a, 32'd0);
    chk("rst_zero", {31'd0, z_a}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 17; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, ra, za, la, rb, zb, lb);
      chk($sformatf("vec%0d_out_s1", i), ra, vecs[i].exp);
      chk($sformatf("vec%0d_zero_s1", i), {31'd0, za}, {31'd0, vecs[i].ez});
      chk($sformatf("vec%0d_lat_s1", i), la, vecs[i].lat1);
      chk($sformatf("vec%0d_out_s8", i), rb, vecs[i].exp);
      chk($sformatf("vec%0d_zero_s8", i), {31'd0, zb}, {31'd0, vecs[i].ez});
      chk($sformatf("vec%0d_lat_s8", i), lb, vecs[i].lat8);
    end

    // SUB 5-5 with consumer stalled for 4 cycles; new operands on the bus must be ignored
    out_ready = 1'b0;
    @(negedge clk);
    operation = 4'd6; in_0 = 32'd5; in_1 = 32'd5; in_valid = 1'b1;
    @(posedge clk);
    #1;
    operation = 4'd2; in_0 = 32'd7; in_1 = 32'd9;
    for (int c = 0; c < 4; c++) begin
      chk("stall_out_valid", {31'd0, ov_a}, 32'd1);
      chk("stall_out", out_a, 32'd0);
      chk("stall_zero", {31'd0, z_a}, 32'd1);
      chk("stall_in_ready", {31'd0, ir_a}, 32'd0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("stall_release_in_ready", {31'd0, ir_a}, 32'd1);
    chk("stall_release_out_valid", {31'd0, ov_a}, 32'd0);

    // Reset in the middle of a long shift
    @(negedge clk);
    operation = 4'd4; in_0 = 32'h00000001; in_1 = 32'd20; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("busy_no_valid", {31'd0, ov_a}, 32'd0);
    chk("busy_in_ready", {31'd0, ir_a}, 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", {31'd0, ov_a}, 32'd0);
    chk("abort_out", out_a, 32'd0);
    chk("abort_in_ready", {31'd0, ir_a}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(4'd2, 32'd2, 32'd3, ra, za, la, rb, zb, lb);
    chk("post_reset_add_out", ra, 32'd5);
    chk("post_reset_add_lat", la, 1);

    // Randomised ops against the reference model
    for (int i = 0; i < 150; i++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      if (($urandom & 3) == 0) a = 32'd0;
      do_op(op, a, b, ra, za, la, rb, zb, lb);
      model(op, a, b, 1, er, el1);
      model(op, a, b, 8, er, el8);
      chk($sformatf("rnd%0d_op%0d_out_s1", i, op), ra, er);
      chk($sformatf("rnd%0d_op%0d_zero_s1", i, op), {31'd0, za}, {31'd0, er == 32'd0});
      chk($sformatf("rnd%0d_op%0d_lat_s1", i, op), la, el1);
      chk($sformatf("rnd%0d_op%0d_out_s8", i, op), rb, er);
      chk($sformatf("rnd%0d_op%0d_lat_s8", i, op), lb, el8);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
